// File: rtl/ps2_pkg.sv
// Scancodes, FSM state types and the digit decoder shared by ps2_number_in.
// PS2_HEX_ENTRY_EN selects base-16 entry and enables the A-F letter keys.
package ps2_pkg;

  localparam logic [7:0] SC_0 = 8'h45;
  localparam logic [7:0] SC_1 = 8'h16;
  localparam logic [7:0] SC_2 = 8'h1E;
  localparam logic [7:0] SC_3 = 8'h26;
  localparam logic [7:0] SC_4 = 8'h25;
  localparam logic [7:0] SC_5 = 8'h2E;
  localparam logic [7:0] SC_6 = 8'h36;
  localparam logic [7:0] SC_7 = 8'h3D;
  localparam logic [7:0] SC_8 = 8'h3E;
  localparam logic [7:0] SC_9 = 8'h46;

  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_B = 8'h32;
  localparam logic [7:0] SC_C = 8'h21;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_E = 8'h24;
  localparam logic [7:0] SC_F = 8'h2B;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

`ifdef PS2_HEX_ENTRY_EN
  localparam int unsigned BASE = 16;
`else
  localparam int unsigned BASE = 10;
`endif

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    DEC_MAKE,
    DEC_BREAK,
    DEC_EXT,
    DEC_EXT_BREAK
  } dec_state_e;

  typedef struct packed {
    logic       is_digit;
    logic [3:0] value;
  } digit_t;

  function automatic digit_t scan_to_digit(input logic [7:0] code);
    digit_t r;
    r.is_digit = 1'b1;
    r.value    = 4'd0;
    case (code)
      SC_0: r.value = 4'd0;
      SC_1: r.value = 4'd1;
      SC_2: r.value = 4'd2;
      SC_3: r.value = 4'd3;
      SC_4: r.value = 4'd4;
      SC_5: r.value = 4'd5;
      SC_6: r.value = 4'd6;
      SC_7: r.value = 4'd7;
      SC_8: r.value = 4'd8;
      SC_9: r.value = 4'd9;
`ifdef PS2_HEX_ENTRY_EN
      SC_A: r.value = 4'd10;
      SC_B: r.value = 4'd11;
      SC_C: r.value = 4'd12;
      SC_D: r.value = 4'd13;
      SC_E: r.value = 4'd14;
      SC_F: r.value = 4'd15;
`endif
      default: r.is_digit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: input synchronisers, falling-edge detect, 11-bit frame FSM
// and inactivity timeout. Emits a one-cycle strobe per good byte, an error pulse otherwise.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       rx_strobe_o,
  output logic [7:0] rx_byte_o,
  output logic       err_o
);

  // state     | meaning
  // RX_IDLE   | waiting for a start bit (data low on a falling edge)
  // RX_DATA   | shifting in 8 data bits, LSB first
  // RX_PARITY | capturing the odd-parity bit
  // RX_STOP   | checking stop bit and parity, then strobe or error

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          clk_prev_q;
  rx_state_e     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          strobe_q, strobe_d;
  logic          err_q, err_d;
  logic          fall, bit_in, timeout;

  // Synchronisers reset to the bus idle level so reset release never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign fall    = clk_prev_q & ~clk_sync_q[1];
  assign bit_in  = data_sync_q[1];
  assign timeout = (state_q != RX_IDLE) && !fall && (tmo_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RX_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tmo_q     <= '0;
      strobe_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tmo_q     <= tmo_d;
      strobe_q  <= strobe_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tmo_d     = tmo_q;
    strobe_d  = 1'b0;
    err_d     = 1'b0;

    if (fall) begin
      tmo_d = TW'(TIMEOUT_CYCLES - 1);
    end else if ((state_q != RX_IDLE) && (tmo_q != '0)) begin
      tmo_d = tmo_q - TW'(1);
    end

    if (timeout) begin
      state_d = RX_IDLE;
      err_d   = 1'b1;
    end else if (fall) begin
      case (state_q)
        RX_IDLE: begin
          if (!bit_in) begin
            state_d   = RX_DATA;
            bit_cnt_d = '0;
          end
        end
        RX_DATA: begin
          shift_d   = {bit_in, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          parity_d = bit_in;
          state_d  = RX_STOP;
        end
        RX_STOP: begin
          if (((^shift_q) ^ parity_q) && bit_in) strobe_d = 1'b1;
          else                                    err_d    = 1'b1;
          state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  assign rx_strobe_o = strobe_q;
  assign rx_byte_o   = shift_q;
  assign err_o       = err_q;

endmodule

// File: rtl/ps2_number_in.sv
// Keyboard number entry for the CPU IN path: decodes set-2 make/break sequences, builds
// a saturating number and commits it on Enter into a show-ahead FIFO. See PS2_HEX_ENTRY_EN.
module ps2_number_in
  import ps2_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] acc_value,
  output logic                  overflow,
  output logic                  frame_err
);

  // state         | meaning
  // DEC_MAKE      | next byte is a key make code or a prefix
  // DEC_BREAK     | next byte is the released key, ignored
  // DEC_EXT       | after E0: F0 leads to EXT_BREAK, anything else is ignored
  // DEC_EXT_BREAK | next byte is the released extended key, ignored

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned WW = 2 * DATA_WIDTH;

  logic       rx_strobe;
  logic [7:0] rx_byte;
  logic       rx_err;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_i  (ps2_clk),
    .ps2_data_i (ps2_data),
    .rx_strobe_o(rx_strobe),
    .rx_byte_o  (rx_byte),
    .err_o      (rx_err)
  );

  dec_state_e            dec_q, dec_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic                  has_digit_q, has_digit_d;
  logic                  push_q, push_d;
  logic [DATA_WIDTH-1:0] push_data_q, push_data_d;
  digit_t                key;
  logic [WW-1:0]         acc_wide;
  logic [DATA_WIDTH-1:0] acc_div;

  assign key      = scan_to_digit(rx_byte);
  assign acc_wide = WW'(acc_q) * WW'(BASE) + WW'(key.value);
  assign acc_div  = acc_q / DATA_WIDTH'(BASE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_q       <= DEC_MAKE;
      acc_q       <= '0;
      has_digit_q <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      dec_q       <= dec_d;
      acc_q       <= acc_d;
      has_digit_q <= has_digit_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
    end
  end

  always_comb begin
    dec_d       = dec_q;
    acc_d       = acc_q;
    has_digit_d = has_digit_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;

    if (rx_strobe) begin
      case (dec_q)
        DEC_MAKE: begin
          if (rx_byte == SC_BREAK) begin
            dec_d = DEC_BREAK;
          end else if (rx_byte == SC_EXT) begin
            dec_d = DEC_EXT;
          end else if (key.is_digit) begin
            acc_d       = (|acc_wide[WW-1:DATA_WIDTH]) ? '1 : acc_wide[DATA_WIDTH-1:0];
            has_digit_d = 1'b1;
          end else if (rx_byte == SC_BKSP) begin
            acc_d = acc_div;
            if (acc_div == '0) has_digit_d = 1'b0;
          end else if (rx_byte == SC_ESC) begin
            acc_d       = '0;
            has_digit_d = 1'b0;
          end else if ((rx_byte == SC_ENTER) && has_digit_q) begin
            push_d      = 1'b1;
            push_data_d = acc_q;
            acc_d       = '0;
            has_digit_d = 1'b0;
          end
        end
        DEC_BREAK:     dec_d = DEC_MAKE;
        DEC_EXT:       dec_d = (rx_byte == SC_BREAK) ? DEC_EXT_BREAK : DEC_MAKE;
        DEC_EXT_BREAK: dec_d = DEC_MAKE;
        default:       dec_d = DEC_MAKE;
      endcase
    end
  end

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW:0]           wr_q, rd_q;
  logic                  overflow_q, frame_err_q;
  logic                  empty, full, pop, push_ok;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign pop     = !empty && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok = push_q && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q[PW-1:0]] <= push_data_q;
        wr_q                <= wr_q + (PW+1)'(1);
      end
      if (pop) rd_q <= rd_q + (PW+1)'(1);
      if (push_q && !push_ok) overflow_q <= 1'b1;
      if (rx_err) frame_err_q <= 1'b1;
    end
  end

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem_q[rd_q[PW-1:0]];
  assign acc_value = acc_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule
